// File: rtl/block_dispatcher.sv
// Block dispatcher: walks the nr x nc grid of C blocks in row-major order and
// hands each (row, column) index pair to the lowest-numbered idle worker CU.
//
// Offer handshake: o_Indexes_Ready[c] rises together with stable index slices
// for CU c and holds until an edge samples i_Indexes_Received[c]=1; that edge
// retires the offer. Only one offer is outstanding at a time, and an
// acknowledge from a CU without a pending offer is ignored.
//
// A CU's busy flag clears only on a rising i_Result_Ready while the flag is
// set, so a result level left high from an earlier job never frees a CU that
// has just been given new work.
module block_dispatcher #(
  parameter int NUM_CU      = 2,
  parameter int index_width = 8
) (
  input  logic                          i_Clock,
  input  logic                          i_Reset,
  input  logic                          i_Start,
  input  logic [index_width-1:0]        i_Row_Blocks,
  input  logic [index_width-1:0]        i_Col_Blocks,
  output logic [NUM_CU*index_width-1:0] o_Row_Index,
  output logic [NUM_CU*index_width-1:0] o_Column_Index,
  output logic [NUM_CU-1:0]             o_Indexes_Ready,
  input  logic [NUM_CU-1:0]             i_Indexes_Received,
  input  logic [NUM_CU-1:0]             i_Result_Ready,
  output logic                          o_Busy,
  output logic                          o_Done,
  output logic [2:0]                    o_State
);

  localparam int SEL_W = (NUM_CU > 1) ? $clog2(NUM_CU) : 1;
  localparam logic [index_width-1:0] ONE = index_width'(1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DISPATCH = 3'd1,
    S_OFFER    = 3'd2,
    S_DRAIN    = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [index_width-1:0] nr_q, nc_q, i_q, j_q;
  logic [SEL_W-1:0]       sel_q, sel_d;
  logic [NUM_CU-1:0]      cu_busy_q, result_q, set_mask, rise;
  logic                   any_free, last_blk, grid_empty;
  logic                   accept, offer, ack_fire, enter_done;

  assign o_State = state_q;

  // Lowest-numbered free CU, plus the grid position tests.
  always_comb begin
    sel_d    = '0;
    any_free = 1'b0;
    for (int c = 0; c < NUM_CU; c++) begin
      if (!any_free && !cu_busy_q[c]) begin
        sel_d    = SEL_W'(c);
        any_free = 1'b1;
      end
    end
    grid_empty = (nr_q == '0) || (nc_q == '0);
    last_blk   = (i_q == nr_q - ONE) && (j_q == nc_q - ONE);
  end

  // State register.
  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic and the one-cycle action strobes that go with it.
  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    offer      = 1'b0;
    ack_fire   = 1'b0;
    enter_done = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (i_Start) begin
          accept  = 1'b1;
          state_d = S_DISPATCH;
        end
      end
      S_DISPATCH: begin
        if (grid_empty) begin
          enter_done = 1'b1;
          state_d    = S_DONE;
        end else if (any_free) begin
          offer   = 1'b1;
          state_d = S_OFFER;
        end
      end
      S_OFFER: begin
        if (i_Indexes_Received[sel_q]) begin
          ack_fire = 1'b1;
          state_d  = last_blk ? S_DRAIN : S_DISPATCH;
        end
      end
      S_DRAIN: begin
        if (cu_busy_q == '0) begin
          enter_done = 1'b1;
          state_d    = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Job registers, grid walk and the registered offer outputs.
  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      nr_q            <= '0;
      nc_q            <= '0;
      i_q             <= '0;
      j_q             <= '0;
      sel_q           <= '0;
      o_Row_Index     <= '0;
      o_Column_Index  <= '0;
      o_Indexes_Ready <= '0;
      o_Busy          <= 1'b0;
      o_Done          <= 1'b0;
    end else begin
      if (accept) begin
        nr_q   <= i_Row_Blocks;
        nc_q   <= i_Col_Blocks;
        i_q    <= '0;
        j_q    <= '0;
        o_Busy <= 1'b1;
        o_Done <= 1'b0;
      end
      if (enter_done) begin
        o_Busy <= 1'b0;
        o_Done <= 1'b1;
      end
      if (offer) begin
        sel_q                                       <= sel_d;
        o_Indexes_Ready[sel_d]                      <= 1'b1;
        o_Row_Index[sel_d*index_width +: index_width]    <= i_q;
        o_Column_Index[sel_d*index_width +: index_width] <= j_q;
      end
      if (ack_fire) begin
        o_Indexes_Ready[sel_q] <= 1'b0;
        if (j_q == nc_q - ONE) begin
          j_q <= '0;
          i_q <= i_q + ONE;
        end else begin
          j_q <= j_q + ONE;
        end
      end
    end
  end

  // Per-CU busy flags: set on the acknowledge edge, cleared by a fresh result.
  always_comb begin
    set_mask = ack_fire ? (NUM_CU'(1) << sel_q) : '0;
    rise     = i_Result_Ready & ~result_q;
  end

  // Busy flag and result history registers.
  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      cu_busy_q <= '0;
      result_q  <= '0;
    end else begin
      result_q  <= i_Result_Ready;
      cu_busy_q <= (cu_busy_q & ~rise) | set_mask;
    end
  end

endmodule

// File: tb/tb_block_dispatcher.sv
// Bench for block_dispatcher: behavioural CU models answer offers, a queue of
// row-major (i,j) pairs predicts every offer, and a negedge monitor checks
// each completed handshake against that queue.
module tb_block_dispatcher;
  localparam int NCU = 2;
  localparam int W   = 8;

  // ---------------- clock / reset ----------------
  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   rows = '0, cols = '0;
  logic [NCU-1:0] recv = '0, rr = '0;
  logic [NCU*W-1:0] row_idx, col_idx;
  logic [NCU-1:0] rdy;
  logic           busy, done;
  logic [2:0]     st;

  always #5 clk = ~clk;

  block_dispatcher #(.NUM_CU(NCU), .index_width(W)) dut (
    .i_Clock(clk), .i_Reset(rst_n), .i_Start(start),
    .i_Row_Blocks(rows), .i_Col_Blocks(cols),
    .o_Row_Index(row_idx), .o_Column_Index(col_idx),
    .o_Indexes_Ready(rdy), .i_Indexes_Received(recv),
    .i_Result_Ready(rr), .o_Busy(busy), .o_Done(done), .o_State(st)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0, errors = 0;
  logic [2*W-1:0] exp_q[$];
  int log_cu[$];
  int done_rises = 0;
  logic done_prev = 1'b0;

  // CU model: phase 0 idle, 1 counting down to acknowledge, 2 working
  int phase[NCU], cnt[NCU], wcnt[NCU], dcnt[NCU];
  int ack_fix[NCU], work_fix[NCU], drop_fix[NCU];
  bit spur_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int a0, input int a1, input int w0, input int w1,
                         input int d0, input int d1);
    ack_fix[0] = a0; ack_fix[1] = a1;
    work_fix[0] = w0; work_fix[1] = w1;
    drop_fix[0] = d0; drop_fix[1] = d1;
  endtask

  // Reference model: every block of the grid, row-major, exactly once.
  task automatic start_job(input int nr, input int nc);
    for (int i = 0; i < nr; i++)
      for (int j = 0; j < nc; j++)
        exp_q.push_back({i[W-1:0], j[W-1:0]});
    log_cu.delete();
    rows  = W'(nr);
    cols  = W'(nc);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    int working;
    n = 0;
    while (!done && n < 3000) begin
      cyc(1);
      n++;
    end
    check({name, "_done_timeout"}, 64'(n < 3000), 64'd1);
    check({name, "_all_offered"}, 64'(exp_q.size()), 64'd0);
    check({name, "_busy_low"}, 64'(busy), 64'd0);
    working = 0;
    for (int c = 0; c < NCU; c++) if (phase[c] == 2) working++;
    check({name, "_results_before_done"}, 64'(working), 64'd0);
  endtask

  // ---------------- driver: CU models ----------------
  initial begin
    for (int c = 0; c < NCU; c++) begin
      phase[c] = 0; cnt[c] = 0; wcnt[c] = 0; dcnt[c] = 0;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int c = 0; c < NCU; c++) begin
        recv[c] = 1'b0;
        if (!rst_n) begin
          phase[c] = 0;
        end else begin
          case (phase[c])
            0: if (rdy[c]) begin
              phase[c] = 1;
              cnt[c]   = (ack_fix[c] >= 0) ? ack_fix[c] : int'($urandom_range(0, 3));
            end
            1: if (cnt[c] == 0) begin
              recv[c]  = 1'b1;
              phase[c] = 2;
              dcnt[c]  = (drop_fix[c] >= 0) ? drop_fix[c] : int'($urandom_range(0, 2));
              wcnt[c]  = (work_fix[c] >= 0) ? work_fix[c] : int'($urandom_range(3, 25));
              if (wcnt[c] < dcnt[c] + 2) wcnt[c] = dcnt[c] + 2;
              if (dcnt[c] == 0) rr[c] = 1'b0;
            end else begin
              cnt[c]--;
            end
            default: begin
              if (dcnt[c] > 0) begin
                dcnt[c]--;
                if (dcnt[c] == 0) rr[c] = 1'b0;
              end
              if (wcnt[c] == 0) begin
                rr[c]    = 1'b1;
                phase[c] = 0;
              end else begin
                wcnt[c]--;
                if (spur_en && $urandom_range(0, 7) == 0) recv[c] = 1'b1;
              end
            end
          endcase
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (done && !done_prev) done_rises++;
      done_prev = done;
      if (rst_n && rdy != '0) begin
        check("offer_onehot", 64'($countones(rdy)), 64'd1);
        for (int c = 0; c < NCU; c++) begin
          if (rdy[c]) check("offer_to_idle_cu", 64'(phase[c] == 2 && !recv[c]), 64'd0);
          if (rdy[c] && recv[c]) begin
            if (exp_q.size() == 0) begin
              check("unexpected_offer", {row_idx[c*W +: W], col_idx[c*W +: W]}, 64'hFFFF_FFFF);
            end else begin
              check("offer_index", {row_idx[c*W +: W], col_idx[c*W +: W]}, exp_q.pop_front());
            end
            log_cu.push_back(c);
          end
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int n, r0;
    set_cfg(-1, -1, -1, -1, -1, -1);
    rr = 2'b10;  // CU1 result level left high from before reset
    cyc(3);
    check("rst_ready", 64'(rdy), 64'd0);
    check("rst_row", 64'(row_idx), 64'd0);
    check("rst_col", 64'(col_idx), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    rst_n = 1'b1;
    cyc(3);
    check("idle_after_reset", 64'(st), 64'd0);
    check("idle_no_busy", 64'(busy), 64'd0);

    // Stale result level on CU1 must not free it after its acknowledge
    set_cfg(0, 0, 30, 10, 0, 5);
    start_job(1, 3);
    wait_done("stale_result");
    check("stale_offers", 64'(log_cu.size()), 64'd3);
    if (log_cu.size() == 3) check("stale_third_cu", 64'(log_cu[2]), 64'd1);

    // 2x2 grid, equal work: third block to the first finisher (CU0)
    set_cfg(0, 0, 20, 20, 0, 0);
    start_job(2, 2);
    wait_done("grid2x2");
    check("grid2x2_offers", 64'(log_cu.size()), 64'd4);
    if (log_cu.size() == 4) begin
      check("grid2x2_cu0", 64'(log_cu[0]), 64'd0);
      check("grid2x2_cu1", 64'(log_cu[1]), 64'd1);
      check("grid2x2_cu2", 64'(log_cu[2]), 64'd0);
      check("grid2x2_cu3", 64'(log_cu[3]), 64'd1);
    end

    // Empty grid: no offer, done two cycles after the start pulse
    start_job(0, 5);
    check("empty_busy_set", 64'(busy), 64'd1);
    check("empty_done_low", 64'(done), 64'd0);
    cyc(1);
    check("empty_done", 64'(done), 64'd1);
    check("empty_busy_clr", 64'(busy), 64'd0);
    check("empty_no_offer", 64'(log_cu.size()), 64'd0);

    // Withheld acknowledge: offer to CU0 holds still for 10 cycles
    set_cfg(10, 0, 5, 5, 0, 0);
    start_job(1, 2);
    cyc(1);
    for (int k = 0; k < 10; k++) begin
      check("hold_ready", 64'(rdy), 64'd1);
      check("hold_index", {row_idx[W-1:0], col_idx[W-1:0]}, 64'd0);
      cyc(1);
    end
    wait_done("hold");

    // Start during DRAIN is ignored; a start from DONE runs a new job
    set_cfg(0, 0, 20, 20, 0, 0);
    start_job(1, 2);
    n = 0;
    while ((exp_q.size() != 0 || rdy != '0) && n < 500) begin
      cyc(1);
      n++;
    end
    check("drain_reach_timeout", 64'(n < 500), 64'd1);
    cyc(1);
    r0 = done_rises;
    rows = 8'd3; cols = 8'd3; start = 1'b1;
    cyc(1);
    start = 1'b0;
    wait_done("drain_start");
    cyc(10);
    check("drain_done_once", 64'(done_rises - r0), 64'd1);
    check("drain_done_held", 64'(done), 64'd1);
    start_job(1, 1);
    wait_done("restart_from_done");
    check("restart_offers", 64'(log_cu.size()), 64'd1);

    // Asynchronous reset in the middle of an offer
    set_cfg(40, 40, 5, 5, 0, 0);
    start_job(3, 3);
    cyc(2);
    check("pre_reset_offer", 64'(rdy), 64'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_ready", 64'(rdy), 64'd0);
    check("async_rst_row", 64'(row_idx), 64'd0);
    check("async_rst_col", 64'(col_idx), 64'd0);
    check("async_rst_busy", 64'(busy), 64'd0);
    check("async_rst_done", 64'(done), 64'd0);
    exp_q.delete();
    cyc(2);
    rst_n = 1'b1;
    set_cfg(-1, -1, -1, -1, -1, -1);
    cyc(2);
    check("post_rst_idle", 64'(st), 64'd0);
    start_job(3, 3);
    wait_done("post_rst_job");

    // Randomized jobs with spurious acknowledges from working CUs
    spur_en = 1'b1;
    for (int t = 0; t < 8; t++) begin
      start_job(int'($urandom_range(1, 4)), int'($urandom_range(1, 4)));
      wait_done("random_job");
      cyc(int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound
  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
